regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 3, is the number of consecutive lost arbitrations after which the ALU requester wins.
REQ-002 Parameter; no other parameters.
REQ-003 clock  in  1  single clock; all state updates on posedge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 alu_valid  in  1  ALU writeback request.
REQ-006 alu_rd  in  5  ALU destination register.
REQ-007 alu_data  in  32  ALU result.
REQ-008 alu_ready  out  1  ALU holding buffer can accept this cycle.
REQ-009 alu_flush  in  1  squash the buffered ALU entry (pipeline flush).
REQ-010 mem_valid  in  1  load writeback request.
REQ-011 mem_rd  in  5  load destination register.
REQ-012 mem_data  in  32  load result.
REQ-013 mem_ready  out  1  load holding buffer can accept this cycle.
REQ-014 rf_write_enable  out  1  registered write enable to the register file.
REQ-015 rf_write_address  out  5  registered write address.
REQ-016 rf_write_data  out  32  registered write data.
REQ-017 pending_mask  out  32  bit k set while a write to xk is buffered or on the rf_write_* outputs.

Function
REQ-018 Each requester SHALL have a one-entry holding buffer {full, rd, data}.
REQ-019 A handshake SHALL occur on a posedge where valid and ready are both high; the buffer loads rd/data and sets full.
REQ-020 ready SHALL be high when the buffer is empty, or when it is full and wins arbitration this cycle.
REQ-021 ready SHALL be low while reset_n is low.
REQ-022 A handshake with rd == 0 SHALL complete, leave the buffer unchanged, and never produce a write.
REQ-023 Arbitration is combinational over full buffers; the winner loads rf_write_* at the next posedge and its buffer clears at that edge.
REQ-024 If only one buffer is full, that buffer SHALL win.
REQ-025 If both buffers are full, mem SHALL win, unless the starvation count equals STARVE_LIMIT; then ALU SHALL win.
REQ-026 The starvation count SHALL increment (saturating at STARVE_LIMIT) on each edge where both buffers are full and mem wins.
REQ-027 The starvation count SHALL clear to 0 when the ALU wins or the ALU buffer is empty.
REQ-028 rf_write_enable SHALL be high for exactly one cycle per grant; it SHALL be 0 on any edge with no full buffer, and rf_write_address/data then hold their last values.
REQ-029 Latency: handshake at edge N gives rf_write_enable high in the cycle after edge N+1 when uncontested.
REQ-030 Sustained throughput is one write per cycle total; a single requester streaming with valid held high SHALL achieve one write per cycle.
REQ-031 When both requesters target the same rd, both writes SHALL occur in grant order, so the last granted data persists.
REQ-032 alu_flush high at an edge SHALL clear the ALU buffer and block any ALU handshake or ALU grant at that edge.
REQ-033 alu_ready SHALL be low while alu_flush is high; mem behaviour is unaffected by alu_flush.
REQ-034 pending_mask SHALL be combinational: the OR of the decoded rd of each full buffer and the decoded rf_write_address when rf_write_enable is high. Bit 0 is always 0.

Reset
REQ-035 On reset_n low, both buffers SHALL be empty, the starvation count 0, rf_write_enable 0, rf_write_address 0, rf_write_data 0, and pending_mask 0, immediately and without a clock.
REQ-036 Reset asserted mid-operation SHALL discard buffered entries; no write SHALL issue after reset_n rises until a new handshake occurs.

Verification
REQ-037 Single ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for one cycle -> two edges later rf_write_enable=1, address 5, data 0xDEADBEEF for one cycle; pending_mask bit5 set from the edge after the handshake until the write cycle ends.
REQ-038 Simultaneous requests: alu rd=3 data=0x11 and mem rd=3 data=0x22 in the same cycle -> mem written first (0x22), ALU (0x11) next cycle; alu_ready low during the contested cycle.
REQ-039 Starvation: mem streams continuously while ALU holds a full buffer -> mem wins 3 times, the ALU wins on the 4th contested edge, then the count clears.
REQ-040 x0 and flush: mem_rd=0 handshake -> no write and pending_mask stays 0; ALU entry buffered then alu_flush=1 -> no ALU write and its mask bit clears.
REQ-041 Async reset: drop reset_n between edges with both buffers full -> all outputs 0 immediately; after release, rf_write_enable stays 0 until new requests arrive.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - two-requester register-file write arbiter
// Load writeback normally wins; a starved ALU entry is forced through after STARVE_LIMIT losses.
module regfile_write_arbiter #(
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   output logic        alu_ready,
   input  logic        alu_flush,
   input  logic        mem_valid,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   output logic        mem_ready,
   output logic        rf_write_enable,
   output logic [4:0]  rf_write_address,
   output logic [31:0] rf_write_data,
   output logic [31:0] pending_mask
);

   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic          alu_full;
   logic [4:0]    alu_rd_q;
   logic [31:0]   alu_data_q;
   logic          mem_full;
   logic [4:0]    mem_rd_q;
   logic [31:0]   mem_data_q;
   logic [CW-1:0] starve;

   logic starved;
   logic alu_grant;
   logic mem_grant;
   logic contested;
   logic alu_take;
   logic mem_take;

   // A flushed ALU entry is out of the contest, so mem wins without counting a loss.
   always_comb begin
      starved   = (starve == CW'(STARVE_LIMIT));
      alu_grant = alu_full && !alu_flush && (!mem_full || starved);
      mem_grant = mem_full && !alu_grant;
      contested = mem_grant && alu_full && !alu_flush;
      alu_ready = reset_n && !alu_flush && (!alu_full || alu_grant);
      mem_ready = reset_n && (!mem_full || mem_grant);
      alu_take  = alu_valid && alu_ready && (alu_rd != 5'd0);
      mem_take  = mem_valid && mem_ready && (mem_rd != 5'd0);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         alu_full         <= 1'b0;
         alu_rd_q         <= 5'd0;
         alu_data_q       <= 32'd0;
         mem_full         <= 1'b0;
         mem_rd_q         <= 5'd0;
         mem_data_q       <= 32'd0;
         starve           <= '0;
         rf_write_enable  <= 1'b0;
         rf_write_address <= 5'd0;
         rf_write_data    <= 32'd0;
      end else begin
         if (alu_take) begin
            alu_full   <= 1'b1;
            alu_rd_q   <= alu_rd;
            alu_data_q <= alu_data;
         end else if (alu_grant || alu_flush) begin
            alu_full <= 1'b0;
         end

         if (mem_take) begin
            mem_full   <= 1'b1;
            mem_rd_q   <= mem_rd;
            mem_data_q <= mem_data;
         end else if (mem_grant) begin
            mem_full <= 1'b0;
         end

         if (contested) begin
            starve <= starved ? starve : starve + 1'b1;
         end else begin
            starve <= '0;
         end

         rf_write_enable <= alu_grant || mem_grant;
         if (alu_grant) begin
            rf_write_address <= alu_rd_q;
            rf_write_data    <= alu_data_q;
         end else if (mem_grant) begin
            rf_write_address <= mem_rd_q;
            rf_write_data    <= mem_data_q;
         end
      end
   end

   always_comb begin
      pending_mask = 32'd0;
      if (alu_full) pending_mask[alu_rd_q] = 1'b1;
      if (mem_full) pending_mask[mem_rd_q] = 1'b1;
      if (rf_write_enable) pending_mask[rf_write_address] = 1'b1;
      pending_mask[0] = 1'b0;
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
// A queue-based reference model predicts readies, writes and pending_mask every cycle.
module tb_regfile_write_arbiter;

   localparam int LIMIT = 3;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        alu_valid = 1'b0;
   logic [4:0]  alu_rd = 5'd0;
   logic [31:0] alu_data = 32'd0;
   logic        alu_ready;
   logic        alu_flush = 1'b0;
   logic        mem_valid = 1'b0;
   logic [4:0]  mem_rd = 5'd0;
   logic [31:0] mem_data = 32'd0;
   logic        mem_ready;
   logic        rf_write_enable;
   logic [4:0]  rf_write_address;
   logic [31:0] rf_write_data;
   logic [31:0] pending_mask;

   always #5 clock = ~clock;

   regfile_write_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset_n(reset_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .alu_ready(alu_ready), .alu_flush(alu_flush),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
      .mem_ready(mem_ready),
      .rf_write_enable(rf_write_enable), .rf_write_address(rf_write_address),
      .rf_write_data(rf_write_data), .pending_mask(pending_mask)
   );

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        alu_q[$];
   ent_t        mem_q[$];
   int          lost;
   logic        exp_we;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   int          checks = 0;
   int          passed = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic bit alu_wins();
      return alu_q.size() != 0 && !alu_flush && (mem_q.size() == 0 || lost == LIMIT);
   endfunction

   function automatic bit mem_wins();
      return mem_q.size() != 0 && !alu_wins();
   endfunction

   function automatic logic [31:0] exp_mask();
      logic [31:0] m = 32'd0;
      foreach (alu_q[i]) m = m | (32'd1 << alu_q[i].rd);
      foreach (mem_q[i]) m = m | (32'd1 << mem_q[i].rd);
      if (exp_we) m = m | (32'd1 << exp_addr);
      m[0] = 1'b0;
      return m;
   endfunction

   task automatic model_reset();
      alu_q.delete();
      mem_q.delete();
      lost     = 0;
      exp_we   = 1'b0;
      exp_addr = 5'd0;
      exp_data = 32'd0;
   endtask

   // Inputs are expected to be stable from just after the previous edge.
   task automatic tick();
      bit   ra, rm, wa, wm, cont;
      ent_t e;
      #2;
      ra = !alu_flush && (alu_q.size() == 0 || alu_wins());
      rm = mem_q.size() == 0 || mem_wins();
      check("alu_ready", 32'(alu_ready), 32'(ra));
      check("mem_ready", 32'(mem_ready), 32'(rm));
      wa   = alu_wins();
      wm   = mem_wins();
      cont = wm && alu_q.size() != 0 && !alu_flush;
      @(posedge clock);
      exp_we = wa || wm;
      if (wa) begin
         e = alu_q.pop_front();
         exp_addr = e.rd;
         exp_data = e.data;
      end else if (wm) begin
         e = mem_q.pop_front();
         exp_addr = e.rd;
         exp_data = e.data;
      end
      if (alu_flush) alu_q.delete();
      lost = cont ? ((lost < LIMIT) ? lost + 1 : LIMIT) : 0;
      if (alu_valid && ra && alu_rd != 5'd0) begin
         e.rd = alu_rd; e.data = alu_data; alu_q.push_back(e);
      end
      if (mem_valid && rm && mem_rd != 5'd0) begin
         e.rd = mem_rd; e.data = mem_data; mem_q.push_back(e);
      end
      #1;
      check("rf_write_enable", 32'(rf_write_enable), 32'(exp_we));
      check("rf_write_address", 32'(rf_write_address), 32'(exp_addr));
      check("rf_write_data", rf_write_data, exp_data);
      check("pending_mask", pending_mask, exp_mask());
   endtask

   task automatic idle();
      alu_valid = 1'b0;
      mem_valid = 1'b0;
      alu_flush = 1'b0;
   endtask

   initial begin
      int mem_before_alu;
      bit alu_seen;
      model_reset();
      #3;
      check("reset_we", 32'(rf_write_enable), 32'd0);
      check("reset_addr", 32'(rf_write_address), 32'd0);
      check("reset_data", rf_write_data, 32'd0);
      check("reset_mask", pending_mask, 32'd0);
      check("reset_alu_ready", 32'(alu_ready), 32'd0);
      check("reset_mem_ready", 32'(mem_ready), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      tick();

      // single ALU write
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      tick();
      idle();
      check("single_mask_buffered", 32'(pending_mask[5]), 32'd1);
      tick();
      check("single_we", 32'(rf_write_enable), 32'd1);
      check("single_addr", 32'(rf_write_address), 32'd5);
      check("single_data", rf_write_data, 32'hDEADBEEF);
      check("single_mask_write", 32'(pending_mask[5]), 32'd1);
      tick();
      check("single_we_drop", 32'(rf_write_enable), 32'd0);
      check("single_mask_clear", pending_mask, 32'd0);

      // simultaneous requests to the same register
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h11;
      mem_valid = 1'b1; mem_rd = 5'd3; mem_data = 32'h22;
      tick();
      idle();
      #1;
      check("contest_alu_ready", 32'(alu_ready), 32'd0);
      tick();
      check("contest_first", rf_write_data, 32'h22);
      tick();
      check("contest_second", rf_write_data, 32'h11);
      tick();

      // starvation: mem streams while ALU holds an entry
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA7;
      mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h100;
      tick();
      alu_valid = 1'b0;
      mem_before_alu = 0;
      alu_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         mem_data = 32'h101 + i;
         tick();
         if (!alu_seen && rf_write_enable && rf_write_address == 5'd8) mem_before_alu++;
         if (rf_write_enable && rf_write_address == 5'd7) alu_seen = 1'b1;
      end
      check("starve_mem_wins", mem_before_alu, LIMIT);
      check("starve_alu_seen", 32'(alu_seen), 32'd1);
      idle();
      tick();
      tick();

      // x0 load and ALU flush
      mem_valid = 1'b1; mem_rd = 5'd0; mem_data = 32'hBAD;
      tick();
      idle();
      check("x0_mask", pending_mask, 32'd0);
      tick();
      check("x0_no_write", 32'(rf_write_enable), 32'd0);
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h99;
      tick();
      idle();
      alu_flush = 1'b1;
      #1;
      check("flush_alu_ready", 32'(alu_ready), 32'd0);
      tick();
      alu_flush = 1'b0;
      check("flush_no_write", 32'(rf_write_enable), 32'd0);
      check("flush_mask", 32'(pending_mask[9]), 32'd0);
      tick();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         alu_valid = 1'($urandom_range(0, 1));
         alu_rd    = 5'($urandom_range(0, 7));
         alu_data  = $urandom;
         mem_valid = 1'($urandom_range(0, 1));
         mem_rd    = 5'($urandom_range(0, 7));
         mem_data  = $urandom;
         alu_flush = ($urandom_range(0, 9) == 0);
         tick();
      end
      idle();
      tick();
      tick();

      // asynchronous reset with both buffers full
      alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'hAAAA;
      mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 32'hBBBB;
      tick();
      idle();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      model_reset();
      check("areset_we", 32'(rf_write_enable), 32'd0);
      check("areset_addr", 32'(rf_write_address), 32'd0);
      check("areset_data", rf_write_data, 32'd0);
      check("areset_mask", pending_mask, 32'd0);
      check("areset_alu_ready", 32'(alu_ready), 32'd0);
      check("areset_mem_ready", 32'(mem_ready), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_reset_no_write", 32'(rf_write_enable), 32'd0);
      end
      alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'hC0DE;
      tick();
      idle();
      tick();
      check("post_reset_write", rf_write_data, 32'hC0DE);
      tick();

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
